// File: rtl/alu_gpr_mem_if.sv
// Bus bundle for alu_gpr_mem: ALU operands/decode, GPR ports and data-memory ports.
interface alu_gpr_mem_if #(
    parameter int unsigned MEM_WIDTH = 32
);
    logic [5:0]           alu_opcode_fwd;
    logic [5:0]           alu_funct_fwd;
    logic [5:0]           alu_opcode;
    logic [5:0]           alu_funct;
    logic [31:0]          alu_rrs;
    logic [31:0]          alu_rrt;
    logic [15:0]          alu_imm;
    logic [4:0]           alu_shamt;
    logic [31:0]          alu_rslt;

    logic [4:0]           gpr_rs;
    logic [4:0]           gpr_rt;
    logic [31:0]          gpr_rrs;
    logic [31:0]          gpr_rrt;
    logic [4:0]           gpr_rd;
    logic [31:0]          gpr_rrd;
    logic                 gpr_we;

    logic [31:0]          mem_addr;
    logic [MEM_WIDTH-1:0] mem_in;
    logic                 mem_we;
    logic [MEM_WIDTH-1:0] mem_out;

    modport master (
        output alu_opcode_fwd, alu_funct_fwd, alu_opcode, alu_funct,
        output alu_rrs, alu_rrt, alu_imm, alu_shamt,
        output gpr_rs, gpr_rt, gpr_rd, gpr_rrd, gpr_we,
        output mem_addr, mem_in, mem_we,
        input  alu_rslt, gpr_rrs, gpr_rrt, mem_out
    );

    modport slave (
        input  alu_opcode_fwd, alu_funct_fwd, alu_opcode, alu_funct,
        input  alu_rrs, alu_rrt, alu_imm, alu_shamt,
        input  gpr_rs, gpr_rt, gpr_rd, gpr_rrd, gpr_we,
        input  mem_addr, mem_in, mem_we,
        output alu_rslt, gpr_rrs, gpr_rrt, mem_out
    );
endinterface

// File: rtl/alu_gpr_mem.sv
// Registered MIPS-style ALU with pre-decoded opcode, 32x32 register file with
// write-through bypass, and a read-first single-port data memory.
module alu_gpr_mem #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MEM_WORD  = 4096
) (
    input  logic          clk,
    input  logic          rst,
    alu_gpr_mem_if.slave  bus
);
    localparam int unsigned MemAw = $clog2(MEM_WORD);

    typedef enum logic [3:0] {
        OpNop, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt,
        OpSltu, OpSll, OpSrl, OpSra, OpSllv, OpSrlv, OpSrav, OpLui
    } alu_op_e;

    typedef enum logic [1:0] {SrcRt, SrcSext, SrcZext} src_e;

    alu_op_e     op_d, op_q;
    src_e        src_d, src_q;
    logic [31:0] opb;
    logic [31:0] rslt_d, rslt_q;

    // Decode the next instruction one cycle early so the execute stage only sees an op code.
    always_comb begin
        op_d  = OpNop;
        src_d = SrcRt;
        if (bus.alu_opcode_fwd == 6'h00) begin
            case (bus.alu_funct_fwd)
                6'h20, 6'h21: op_d = OpAdd;
                6'h22, 6'h23: op_d = OpSub;
                6'h24:        op_d = OpAnd;
                6'h25:        op_d = OpOr;
                6'h26:        op_d = OpXor;
                6'h27:        op_d = OpNor;
                6'h2A:        op_d = OpSlt;
                6'h2B:        op_d = OpSltu;
                6'h00:        op_d = OpSll;
                6'h02:        op_d = OpSrl;
                6'h03:        op_d = OpSra;
                6'h04:        op_d = OpSllv;
                6'h06:        op_d = OpSrlv;
                6'h07:        op_d = OpSrav;
                default:      op_d = OpNop;
            endcase
        end else begin
            case (bus.alu_opcode_fwd)
                6'h08, 6'h09, 6'h23, 6'h2B: begin op_d = OpAdd;  src_d = SrcSext; end
                6'h0A:                      begin op_d = OpSlt;  src_d = SrcSext; end
                6'h0B:                      begin op_d = OpSltu; src_d = SrcSext; end
                6'h0C:                      begin op_d = OpAnd;  src_d = SrcZext; end
                6'h0D:                      begin op_d = OpOr;   src_d = SrcZext; end
                6'h0E:                      begin op_d = OpXor;  src_d = SrcZext; end
                6'h0F:                      op_d = OpLui;
                default:                    op_d = OpNop;
            endcase
        end
    end

    // Decode register; reset value is the no-op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= OpNop;
            src_q <= SrcRt;
        end else begin
            op_q  <= op_d;
            src_q <= src_d;
        end
    end

    // Execute with the latched decode and the current operands.
    always_comb begin
        opb = bus.alu_rrt;
        if (src_q == SrcSext) begin
            opb = {{16{bus.alu_imm[15]}}, bus.alu_imm};
        end else if (src_q == SrcZext) begin
            opb = {16'h0000, bus.alu_imm};
        end
        rslt_d = '0;
        case (op_q)
            OpAdd:   rslt_d = bus.alu_rrs + opb;
            OpSub:   rslt_d = bus.alu_rrs - opb;
            OpAnd:   rslt_d = bus.alu_rrs & opb;
            OpOr:    rslt_d = bus.alu_rrs | opb;
            OpXor:   rslt_d = bus.alu_rrs ^ opb;
            OpNor:   rslt_d = ~(bus.alu_rrs | opb);
            OpSlt:   rslt_d = {31'b0, $signed(bus.alu_rrs) < $signed(opb)};
            OpSltu:  rslt_d = {31'b0, bus.alu_rrs < opb};
            OpSll:   rslt_d = bus.alu_rrt << bus.alu_shamt;
            OpSrl:   rslt_d = bus.alu_rrt >> bus.alu_shamt;
            OpSra:   rslt_d = $signed(bus.alu_rrt) >>> bus.alu_shamt;
            OpSllv:  rslt_d = bus.alu_rrt << bus.alu_rrs[4:0];
            OpSrlv:  rslt_d = bus.alu_rrt >> bus.alu_rrs[4:0];
            OpSrav:  rslt_d = $signed(bus.alu_rrt) >>> bus.alu_rrs[4:0];
            OpLui:   rslt_d = {bus.alu_imm, 16'h0000};
            default: rslt_d = '0;
        endcase
    end

    // ALU result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rslt_q <= '0;
        end else begin
            rslt_q <= rslt_d;
        end
    end

    assign bus.alu_rslt = rslt_q;

    // Current opcode/funct only mirror the forwarded decode; they carry no extra information.
    logic unused_cur;
    assign unused_cur = ^{bus.alu_opcode, bus.alu_funct};

    logic [31:0] gpr_q [32];
    logic        gpr_wr;

    // Reset gates both the write and the bypass so reads see zeros while held.
    assign gpr_wr = rst && bus.gpr_we && (bus.gpr_rd != 5'd0);

    // Register file; entry 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_wr) begin
            gpr_q[bus.gpr_rd] <= bus.gpr_rrd;
        end
    end

    // Combinational reads with write-through bypass.
    always_comb begin
        bus.gpr_rrs = '0;
        bus.gpr_rrt = '0;
        if (bus.gpr_rs != 5'd0) begin
            bus.gpr_rrs = (gpr_wr && bus.gpr_rd == bus.gpr_rs) ? bus.gpr_rrd : gpr_q[bus.gpr_rs];
        end
        if (bus.gpr_rt != 5'd0) begin
            bus.gpr_rrt = (gpr_wr && bus.gpr_rd == bus.gpr_rt) ? bus.gpr_rrd : gpr_q[bus.gpr_rt];
        end
    end

    logic [MEM_WIDTH-1:0] mem_q [MEM_WORD];
    logic [MemAw-1:0]     mem_idx;
    logic [MEM_WIDTH-1:0] mem_out_q;

    // Upper address bits wrap onto the array.
    assign mem_idx = bus.mem_addr[MemAw-1:0];

    logic unused_addr;
    assign unused_addr = ^bus.mem_addr[31:MemAw];

    // Memory array is never cleared; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (rst && bus.mem_we) begin
            mem_q[mem_idx] <= bus.mem_in;
        end
    end

    // Read-first registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_out_q <= '0;
        end else begin
            mem_out_q <= mem_q[mem_idx];
        end
    end

    assign bus.mem_out = mem_out_q;
endmodule

// File: tb/tb_alu_gpr_mem.sv
// Randomised scoreboard bench for alu_gpr_mem against a behavioural model.
module tb_alu_gpr_mem;
    localparam int unsigned MemWord = 4096;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    alu_gpr_mem_if #(.MEM_WIDTH(32)) bus ();

    alu_gpr_mem #(.MEM_WIDTH(32), .MEM_WORD(MemWord)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] rrs; logic [31:0] rrt; } gpr_exp_t;
    typedef struct { logic [31:0] alu; bit mem_chk; logic [31:0] mem; } reg_exp_t;

    gpr_exp_t gpr_sb[$];
    reg_exp_t reg_sb[$];

    // Stimulus for the cycle being driven.
    logic [5:0]  s_fop, s_ffn;
    logic [31:0] s_a, s_b, s_gdata, s_maddr, s_min;
    logic [15:0] s_imm;
    logic [4:0]  s_sh, s_grs, s_grt, s_grd;
    logic        s_gwe, s_mwe;

    // Model state.
    logic [5:0]  cur_op, cur_fn;
    logic [31:0] gpr_m [32];
    logic [31:0] mem_m [int];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [15:0] imm, input logic [4:0] sh);
        logic [31:0] se, ze, r;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        r  = 32'h0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = $signed(b) >>> sh;
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = $signed(b) >>> a[4:0];
                default: r = 32'h0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h23, 6'h2B: r = a + se;
                6'h0A: r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0B: r = (a < se) ? 32'd1 : 32'd0;
                6'h0C: r = a & ze;
                6'h0D: r = a | ze;
                6'h0E: r = a ^ ze;
                6'h0F: r = {imm, 16'h0};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] gpr_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (s_gwe && s_grd == idx) return s_gdata;
        return gpr_m[idx];
    endfunction

    task automatic set_idle();
        s_fop = 6'h02; s_ffn = 6'h00; s_a = 0; s_b = 0; s_imm = 0; s_sh = 0;
        s_grs = 0; s_grt = 0; s_grd = 0; s_gdata = 0; s_gwe = 0;
        s_maddr = 0; s_min = 0; s_mwe = 0;
    endtask

    // Drive one cycle (called just after a falling edge), record expectations, advance the model.
    task automatic cycle();
        gpr_exp_t g;
        reg_exp_t r;
        int       idx;
        bus.alu_opcode = cur_op;   bus.alu_funct = cur_fn;
        bus.alu_opcode_fwd = s_fop; bus.alu_funct_fwd = s_ffn;
        bus.alu_rrs = s_a; bus.alu_rrt = s_b; bus.alu_imm = s_imm; bus.alu_shamt = s_sh;
        bus.gpr_rs = s_grs; bus.gpr_rt = s_grt; bus.gpr_rd = s_grd;
        bus.gpr_rrd = s_gdata; bus.gpr_we = s_gwe;
        bus.mem_addr = s_maddr; bus.mem_in = s_min; bus.mem_we = s_mwe;
        g.rrs = gpr_read(s_grs);
        g.rrt = gpr_read(s_grt);
        gpr_sb.push_back(g);
        idx = int'(s_maddr % MemWord);
        r.alu = alu_ref(cur_op, cur_fn, s_a, s_b, s_imm, s_sh);
        r.mem_chk = mem_m.exists(idx);
        r.mem = r.mem_chk ? mem_m[idx] : 32'h0;
        reg_sb.push_back(r);
        if (s_gwe && s_grd != 0) gpr_m[s_grd] = s_gdata;
        if (s_mwe) mem_m[idx] = s_min;
        cur_op = s_fop;
        cur_fn = s_ffn;
        @(negedge clk);
    endtask

    // Monitor: combinational GPR reads before the edge, registered outputs after it.
    initial begin
        gpr_exp_t g;
        reg_exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (gpr_sb.size() > 0) begin
                g = gpr_sb.pop_front();
                check("gpr_rrs", bus.gpr_rrs, g.rrs);
                check("gpr_rrt", bus.gpr_rrt, g.rrt);
            end
            @(posedge clk);
            #1;
            if (reg_sb.size() > 0) begin
                r = reg_sb.pop_front();
                check("alu_rslt", bus.alu_rslt, r.alu);
                if (r.mem_chk) check("mem_out", bus.mem_out, r.mem);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rand_opnd();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0] ops [18];
        logic [5:0] fns [18];
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
        for (int i = 0; i < 32; i++) gpr_m[i] = 0;
        cur_op = 6'h02; cur_fn = 6'h00;
        set_idle();
        rst = 1'b0;
        bus.alu_opcode = 6'h02; bus.alu_funct = 0; bus.alu_opcode_fwd = 6'h02;
        bus.alu_funct_fwd = 0; bus.alu_rrs = 0; bus.alu_rrt = 0; bus.alu_imm = 0;
        bus.alu_shamt = 0; bus.gpr_rs = 5'd1; bus.gpr_rt = 5'd31; bus.gpr_rd = 0;
        bus.gpr_rrd = 0; bus.gpr_we = 0; bus.mem_addr = 0; bus.mem_in = 0; bus.mem_we = 0;
        repeat (3) @(negedge clk);
        check("reset_alu_rslt", bus.alu_rslt, 32'h0);
        check("reset_mem_out", bus.mem_out, 32'h0);
        check("reset_gpr_rrs", bus.gpr_rrs, 32'h0);
        check("reset_gpr_rrt", bus.gpr_rrt, 32'h0);
        rst = 1'b1;

        // ALU directed: ADD, SUB, SLT, SLTU, LUI, ORI.
        set_idle(); s_fop = 6'h00; s_ffn = 6'h20; cycle();
        set_idle(); s_fop = 6'h00; s_ffn = 6'h22; s_a = 5; s_b = 7; cycle();
        set_idle(); s_fop = 6'h00; s_ffn = 6'h2A; s_a = 5; s_b = 7; cycle();
        set_idle(); s_fop = 6'h00; s_ffn = 6'h2B; s_a = 32'hFFFF_FFFF; s_b = 1; cycle();
        set_idle(); s_fop = 6'h0F; s_a = 32'hFFFF_FFFF; s_b = 1; cycle();
        set_idle(); s_fop = 6'h0D; s_imm = 16'h1234; cycle();
        set_idle(); s_a = 32'hF0; s_imm = 16'h8001; cycle();

        // GPR directed: bypass, hold, r0 write.
        set_idle(); s_gwe = 1; s_grd = 3; s_gdata = 32'hDEAD_BEEF; s_grs = 3; cycle();
        set_idle(); s_grs = 3; s_grt = 3; cycle();
        set_idle(); s_gwe = 1; s_grd = 0; s_gdata = 32'hFFFF_FFFF; cycle();
        set_idle(); s_grs = 0; s_grt = 3; cycle();

        // MEM directed: write, read, wrap alias, read-during-write.
        set_idle(); s_mwe = 1; s_maddr = 4; s_min = 32'hA5; cycle();
        set_idle(); s_maddr = 4; cycle();
        set_idle(); s_maddr = 4 + MemWord; cycle();
        set_idle(); s_mwe = 1; s_maddr = 4; s_min = 32'h5A; cycle();
        set_idle(); s_maddr = 4; cycle();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            s_fop = ops[$urandom_range(0, 17)];
            s_ffn = (s_fop == 6'h00) ? fns[$urandom_range(0, 17)] : 6'($urandom);
            s_a = rand_opnd(); s_b = rand_opnd();
            s_imm = 16'($urandom); s_sh = 5'($urandom);
            s_gwe = $urandom_range(0, 1) == 1;
            s_grd = 5'($urandom); s_gdata = $urandom;
            s_grs = ($urandom_range(0, 2) == 0) ? s_grd : 5'($urandom);
            s_grt = 5'($urandom);
            s_mwe = $urandom_range(0, 1) == 1;
            s_maddr = $urandom_range(0, 3) * MemWord + $urandom_range(0, 15);
            s_min = $urandom;
            cycle();
        end

        // Leave nonzero state and an ADD in the decode register, then reset mid-operation.
        set_idle(); s_fop = 6'h00; s_ffn = 6'h20; s_a = 5; s_b = 7; cycle();
        set_idle(); s_a = 5; s_b = 7; s_maddr = 4; cycle();
        set_idle(); s_fop = 6'h00; s_ffn = 6'h20; s_a = 1; s_b = 2; s_maddr = 4; cycle();
        rst = 1'b0;
        #1;
        check("async_alu_rslt", bus.alu_rslt, 32'h0);
        check("async_mem_out", bus.mem_out, 32'h0);
        for (int i = 1; i < 32; i++) begin
            bus.gpr_rs = 5'(i);
            bus.gpr_rt = 5'(32 - i);
            #1;
            check("async_gpr_rrs", bus.gpr_rrs, 32'h0);
            check("async_gpr_rrt", bus.gpr_rrt, 32'h0);
        end
        for (int i = 0; i < 32; i++) gpr_m[i] = 0;
        cur_op = 6'h02; cur_fn = 6'h00;
        @(negedge clk);
        rst = 1'b1;

        // After release: decode is a no-op, GPRs are clear, memory survives.
        set_idle(); s_a = 5; s_b = 7; s_maddr = 4; s_grs = 3; cycle();
        set_idle(); s_maddr = 4 + 2 * MemWord; s_grt = 3; cycle();
        set_idle(); s_gwe = 1; s_grd = 7; s_gdata = 32'h1234_5678; cycle();
        set_idle(); s_grs = 7; cycle();
        set_idle(); cycle();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
